// File: rtl/hb_interp_sched_if.sv
// Configuration, upstream handshake and strobe bundle between the TX controller and hb_interp_sched.
interface hb_interp_sched_if;
    logic       run;
    logic [7:0] cpo;
    logic       bypass_cfg;
    logic       clear_status;
    logic       src_valid;
    logic       src_ack;
    logic       zero_fill;
    logic       stb_in;
    logic       stb_out;
    logic [7:0] cpo_hb;
    logic       bypass;
    logic       active;
    logic       underrun;
    logic       cfg_err;

    modport master (
        output run, cpo, bypass_cfg, clear_status, src_valid,
        input  src_ack, zero_fill, stb_in, stb_out, cpo_hb, bypass, active, underrun, cfg_err
    );

    modport slave (
        input  run, cpo, bypass_cfg, clear_status, src_valid,
        output src_ack, zero_fill, stb_in, stb_out, cpo_hb, bypass, active, underrun, cfg_err
    );
endinterface

// File: rtl/hb_interp_sched.sv
// Strobe scheduler and config latch for the first TX halfband interpolator.
// Every output is a register loaded from the next-state decode, so strobes line up with the counter state.
module hb_interp_sched (
    input  logic             clk,
    input  logic             rst,
    hb_interp_sched_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pb_q, pb_d;
    logic [7:0] cpo_l_q, cpo_l_d;
    logic       byp_l_q, byp_l_d;
    logic       run_q;
    logic       stb_in_q, stb_out_q, src_ack_q, zero_fill_q, active_q;
    logic       underrun_q, cfg_err_q;
    logic       stb_in_d, stb_out_d, cfg_set, ur_set;
    logic       run_rise, period_end, pair_end;

    assign run_rise   = bus.run & ~run_q;
    assign period_end = (cnt_q == cpo_l_q - 8'd1);
    assign pair_end   = period_end & (pb_q | byp_l_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pb_d    = pb_q;
        cpo_l_d = cpo_l_q;
        byp_l_d = byp_l_q;
        cfg_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                pb_d  = 1'b0;
                if (run_rise) begin
                    if (bus.cpo == 8'd1) begin
                        cfg_set = 1'b1;
                    end else begin
                        cpo_l_d = bus.cpo;
                        byp_l_d = bus.bypass_cfg;
                        state_d = S_PRIME;
                    end
                end
            end
            S_PRIME: begin
                if (!bus.run) begin
                    state_d = S_IDLE;
                end else if (bus.src_valid) begin
                    state_d = S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                if (period_end) begin
                    cnt_d = '0;
                    pb_d  = ~pb_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                // A stop seen on the last cycle of a pair has nothing left to drain.
                if (state_q == S_RUN && bus.run) begin
                    state_d = S_RUN;
                end else if (pair_end) begin
                    state_d = S_IDLE;
                    pb_d    = 1'b0;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        stb_in_d  = (state_d == S_RUN) && (cnt_d == '0) && (!pb_d || byp_l_d);
        stb_out_d = ((state_d == S_RUN) || (state_d == S_DRAIN)) && (cnt_d == cpo_l_d - 8'd1);
        ur_set    = stb_in_d && !bus.src_valid;
    end

    always_ff @(posedge clk) begin
        // Tracks run through reset so a level held across reset is not taken as a start.
        run_q <= bus.run;
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pb_q        <= 1'b0;
            cpo_l_q     <= 8'd2;
            byp_l_q     <= 1'b0;
            stb_in_q    <= 1'b0;
            stb_out_q   <= 1'b0;
            src_ack_q   <= 1'b0;
            zero_fill_q <= 1'b0;
            active_q    <= 1'b0;
            underrun_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pb_q        <= pb_d;
            cpo_l_q     <= cpo_l_d;
            byp_l_q     <= byp_l_d;
            stb_in_q    <= stb_in_d;
            stb_out_q   <= stb_out_d;
            src_ack_q   <= stb_in_d & bus.src_valid;
            zero_fill_q <= ur_set;
            active_q    <= (state_d != S_IDLE);
            if (ur_set) begin
                underrun_q <= 1'b1;
            end else if (bus.clear_status) begin
                underrun_q <= 1'b0;
            end
            if (cfg_set) begin
                cfg_err_q <= 1'b1;
            end else if (bus.clear_status) begin
                cfg_err_q <= 1'b0;
            end
        end
    end

    assign bus.stb_in    = stb_in_q;
    assign bus.stb_out   = stb_out_q;
    assign bus.src_ack   = src_ack_q;
    assign bus.zero_fill = zero_fill_q;
    assign bus.active    = active_q;
    assign bus.underrun  = underrun_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.cpo_hb    = cpo_l_q;
    assign bus.bypass    = byp_l_q;
endmodule

// File: tb/tb_hb_interp_sched.sv
// Randomised scenario bench for hb_interp_sched against a period-arithmetic reference model.
module tb_hb_interp_sched;
    logic clk = 1'b0;
    logic rst;
    int   n_pass   = 0;
    int   n_checks = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hb_interp_sched_if bus ();

    hb_interp_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: t counts cycles since RUN entry; strobes follow from t modulo the period length.
    int unsigned m_mode = 0;
    int unsigned m_t    = 0;
    int unsigned m_stop = 0;
    bit          m_drain = 1'b0;
    logic [7:0]  m_cpo;
    logic        m_byp, m_runp, m_ur, m_cfg;
    logic        e_in, e_out, e_ack, e_zf;
    logic [15:0] dut_v, exp_v;

    always @(posedge clk) begin : model_b
        int unsigned mode, t, stop, c, per;
        bit          drain, si, so, ur, cfg, set_cfg;
        logic [7:0]  cl;
        logic        byp;
        mode = m_mode; t = m_t; stop = m_stop; drain = m_drain;
        cl = m_cpo; byp = m_byp; ur = m_ur; cfg = m_cfg;
        si = 1'b0; so = 1'b0; set_cfg = 1'b0;
        if (rst) begin
            mode = 0; cl = 8'd2; byp = 1'b0; ur = 1'b0; cfg = 1'b0;
        end else begin
            c   = (cl == 8'd0) ? 256 : {24'd0, cl};
            per = byp ? c : 2 * c;
            case (mode)
                0: if (bus.run && !m_runp) begin
                       if (bus.cpo == 8'd1) set_cfg = 1'b1;
                       else begin cl = bus.cpo; byp = bus.bypass_cfg; mode = 1; end
                   end
                1: if (!bus.run) mode = 0;
                   else if (bus.src_valid) begin mode = 2; t = 0; drain = 1'b0; end
                default: begin
                    if (!drain && !bus.run) begin
                        drain = 1'b1;
                        stop  = (t / per + 1) * per - 1;
                    end
                    if (drain && t == stop) mode = 0;
                    else t = t + 1;
                end
            endcase
            c   = (cl == 8'd0) ? 256 : {24'd0, cl};
            per = byp ? c : 2 * c;
            if (mode == 2) begin
                si = !drain && (t % per == 0);
                so = (t % c == c - 1);
            end
            if (si && !bus.src_valid) ur = 1'b1;
            else if (bus.clear_status) ur = 1'b0;
            if (set_cfg) cfg = 1'b1;
            else if (bus.clear_status) cfg = 1'b0;
        end
        m_mode <= mode; m_t <= t; m_stop <= stop; m_drain <= drain;
        m_cpo <= cl; m_byp <= byp; m_ur <= ur; m_cfg <= cfg;
        m_runp <= bus.run;
        e_in <= si; e_out <= so;
        e_ack <= si && bus.src_valid;
        e_zf  <= si && !bus.src_valid;
    end

    assign dut_v = {bus.stb_in, bus.stb_out, bus.src_ack, bus.zero_fill, bus.active,
                    bus.underrun, bus.cfg_err, bus.bypass, bus.cpo_hb};
    assign exp_v = {e_in, e_out, e_ack, e_zf, (m_mode != 0), m_ur, m_cfg, m_byp, m_cpo};

    task automatic test_reset();
        rst = 1'b1; bus.run = 1'b1; bus.cpo = 8'd4; bus.bypass_cfg = 1'b0;
        bus.clear_status = 1'b0; bus.src_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.stb_in, bus.stb_out, bus.src_ack, bus.zero_fill, bus.active,
                 bus.underrun, bus.cfg_err, bus.bypass} !== 8'h00 || bus.cpo_hb !== 8'd2)
                $display("FAIL reset cyc=%0d got=%h exp=0002", cyc, dut_v);
            else n_pass++;
        end
        bus.run = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cpo4();
        int start, first_in = -1, first_out = -1, last_in = -1, last_out = -1;
        int n_in = 0, n_ack = 0, idle_at = -1;
        bit done = 1'b0;
        bus.cpo = 8'd4; bus.bypass_cfg = 1'b0; bus.src_valid = 1'b1; bus.run = 1'b1;
        start = cyc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL cpo4_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
            if (bus.stb_in) begin
                if (last_in >= 0) begin
                    n_checks++;
                    if (cyc - last_in != 8) $display("FAIL cpo4_in_spacing got=%0d exp=8", cyc - last_in);
                    else n_pass++;
                end
                if (first_in < 0) first_in = cyc;
                last_in = cyc;
                n_in++;
            end
            if (bus.src_ack) n_ack++;
            if (bus.stb_out && first_out < 0) first_out = cyc;
        end
        n_checks++;
        if (first_in - start != 2) $display("FAIL cpo4_first_in_latency got=%0d exp=2", first_in - start);
        else n_pass++;
        n_checks++;
        if (first_out - first_in != 3) $display("FAIL cpo4_first_out_offset got=%0d exp=3", first_out - first_in);
        else n_pass++;
        n_checks++;
        if (n_in != 5 || n_ack != n_in) $display("FAIL cpo4_ack_count got=%0d/%0d exp=5/5", n_ack, n_in);
        else n_pass++;
        bus.run = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL cpo4_drain_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
            if (bus.stb_out) last_out = cyc;
            if (!bus.active) begin done = 1'b1; idle_at = cyc; end
        end
        n_checks++;
        if (!done || idle_at != last_out + 1)
            $display("FAIL cpo4_drain_end got=%0d exp=%0d", idle_at, last_out + 1);
        else n_pass++;
    endtask

    task automatic test_cpo2();
        int last_in = -1, last_out = -1;
        bit done = 1'b0;
        bus.cpo = 8'd2; bus.bypass_cfg = 1'b0; bus.run = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.src_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL cpo2_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
            if (bus.stb_in) begin
                if (last_in >= 0) begin
                    n_checks++;
                    if (cyc - last_in != 4) $display("FAIL cpo2_in_spacing got=%0d exp=4", cyc - last_in);
                    else n_pass++;
                end
                last_in = cyc;
            end
            if (bus.stb_out) begin
                if (last_out >= 0) begin
                    n_checks++;
                    if (cyc - last_out != 2) $display("FAIL cpo2_out_spacing got=%0d exp=2", cyc - last_out);
                    else n_pass++;
                end
                last_out = cyc;
            end
        end
        bus.run = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL cpo2_drain_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
            if (!bus.active) done = 1'b1;
        end
        n_checks++;
        if (!done) $display("FAIL cpo2_drain_timeout got=active exp=idle");
        else n_pass++;
        bus.src_valid = 1'b1; bus.clear_status = 1'b1;
        @(negedge clk);
        bus.clear_status = 1'b0;
        n_checks++;
        if (bus.underrun !== 1'b0) $display("FAIL cpo2_clear got=%b exp=0", bus.underrun);
        else n_pass++;
    endtask

    task automatic test_cpo0();
        int last_in = -1, last_out = -1;
        bit done = 1'b0;
        bus.cpo = 8'd0; bus.bypass_cfg = 1'b0; bus.src_valid = 1'b1; bus.run = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL cpo0_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
            if (bus.stb_in) begin
                if (last_in >= 0) begin
                    n_checks++;
                    if (cyc - last_in != 512) $display("FAIL cpo0_in_spacing got=%0d exp=512", cyc - last_in);
                    else n_pass++;
                end
                last_in = cyc;
            end
            if (bus.stb_out) begin
                if (last_out >= 0) begin
                    n_checks++;
                    if (cyc - last_out != 256) $display("FAIL cpo0_out_spacing got=%0d exp=256", cyc - last_out);
                    else n_pass++;
                end
                last_out = cyc;
            end
        end
        bus.run = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL cpo0_drain_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
            if (!bus.active) done = 1'b1;
        end
        n_checks++;
        if (!done) $display("FAIL cpo0_drain_timeout got=active exp=idle");
        else n_pass++;
    endtask

    task automatic test_cfg_err();
        bus.cpo = 8'd1; bus.run = 1'b1; bus.clear_status = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.clear_status = 1'b0;
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL cfg_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
            n_checks++;
            if ({bus.cfg_err, bus.active, bus.stb_in, bus.stb_out} !== 4'b1000)
                $display("FAIL cfg_err_state got=%b exp=1000", {bus.cfg_err, bus.active, bus.stb_in, bus.stb_out});
            else n_pass++;
        end
        bus.run = 1'b0; bus.clear_status = 1'b1;
        @(negedge clk);
        bus.clear_status = 1'b0;
        n_checks++;
        if (bus.cfg_err !== 1'b0) $display("FAIL cfg_clear got=%b exp=0", bus.cfg_err);
        else n_pass++;
    endtask

    task automatic test_underrun();
        bit seen = 1'b0, done = 1'b0;
        bus.cpo = 8'd4; bus.bypass_cfg = 1'b0; bus.src_valid = 1'b1; bus.run = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.stb_in) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL ur_first_strobe_timeout got=none exp=stb_in");
        else n_pass++;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL ur_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
            if (j == 7) bus.src_valid = 1'b0;
            if (j == 8) begin
                n_checks++;
                if ({bus.stb_in, bus.zero_fill, bus.src_ack, bus.underrun} !== 4'b1101)
                    $display("FAIL ur_slot got=%b exp=1101", {bus.stb_in, bus.zero_fill, bus.src_ack, bus.underrun});
                else n_pass++;
                bus.src_valid = 1'b1;
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL ur_after_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
        end
        n_checks++;
        if (bus.underrun !== 1'b1) $display("FAIL ur_sticky got=%b exp=1", bus.underrun);
        else n_pass++;
        bus.clear_status = 1'b1;
        @(negedge clk);
        bus.clear_status = 1'b0;
        n_checks++;
        if (bus.underrun !== 1'b0) $display("FAIL ur_clear got=%b exp=0", bus.underrun);
        else n_pass++;
        bus.run = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL ur_drain_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
            if (!bus.active) done = 1'b1;
        end
        n_checks++;
        if (!done) $display("FAIL ur_drain_timeout got=active exp=idle");
        else n_pass++;
    endtask

    task automatic test_bypass();
        int last_in = -1, last_out = -1;
        bit done = 1'b0;
        bus.cpo = 8'd3; bus.bypass_cfg = 1'b1; bus.src_valid = 1'b1; bus.run = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL byp_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
            if (bus.stb_in) begin
                if (last_in >= 0) begin
                    n_checks++;
                    if (cyc - last_in != 3) $display("FAIL byp_in_spacing got=%0d exp=3", cyc - last_in);
                    else n_pass++;
                end
                last_in = cyc;
            end
            if (bus.stb_out) begin
                n_checks++;
                if (cyc - last_in != 2 || (last_out >= 0 && cyc - last_out != 3))
                    $display("FAIL byp_out_timing got=%0d/%0d exp=2/3", cyc - last_in, cyc - last_out);
                else n_pass++;
                last_out = cyc;
            end
            if (i == 10) begin bus.cpo = 8'($urandom_range(4, 255)); bus.bypass_cfg = 1'b0; end
        end
        n_checks++;
        if (bus.cpo_hb !== 8'd3 || bus.bypass !== 1'b1)
            $display("FAIL byp_cfg_hold got=%0d/%b exp=3/1", bus.cpo_hb, bus.bypass);
        else n_pass++;
        bus.run = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL byp_drain_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
            if (!bus.active) done = 1'b1;
        end
        n_checks++;
        if (!done) $display("FAIL byp_drain_timeout got=active exp=idle");
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.cpo = 8'd5; bus.bypass_cfg = 1'b1; bus.src_valid = 1'b1; bus.run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.active, bus.stb_in, bus.stb_out, bus.bypass} !== 4'b0000 || bus.cpo_hb !== 8'd2)
            $display("FAIL rstmid_state got=%h exp=0002", dut_v);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v || bus.active !== 1'b0)
                $display("FAIL rstmid_quiet cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
        end
        bus.run = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rise_in_drain();
        bit done = 1'b0;
        bus.cpo = 8'd6; bus.bypass_cfg = 1'b0; bus.src_valid = 1'b1; bus.run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL rid_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
        end
        bus.run = 1'b0;
        @(negedge clk);
        bus.run = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== exp_v) $display("FAIL rid_drain_model cyc=%0d got=%h exp=%h", cyc, dut_v, exp_v);
            else n_pass++;
            if (!bus.active) done = 1'b1;
        end
        n_checks++;
        if (!done) $display("FAIL rid_drain_timeout got=active exp=idle");
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.active !== 1'b0 || bus.stb_in !== 1'b0)
                $display("FAIL rid_no_restart cyc=%0d got=%b%b exp=00", cyc, bus.active, bus.stb_in);
            else n_pass++;
        end
        bus.run = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cpo4();
        test_cpo2();
        test_cpo0();
        test_cfg_err();
        test_underrun();
        test_bypass();
        test_reset_mid();
        test_rise_in_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
